mux2to1_arbiter: RTL and testbench

//  - Round-robin packet arbiter that shares one 2:1 datapath mux between two

---
 rtl/mux2to1_arb_pkg.sv | 20 ++
 rtl/mux2to1_bus.sv | 23 ++
 rtl/mux2to1_arbiter.sv | 116 +++++++++++
 tb/tb_mux2to1_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux2to1_arb_pkg.sv
// Shared definitions for the two-source packet arbiter.
//   state_t   : arbiter FSM encoding (IDLE, SEL0, SEL1)
//   CH0 / CH1 : channel identifiers, also used as mux select values
//   sel_state : maps a channel id to the state that grants it
package mux2to1_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL0 = 2'd1,
    SEL1 = 2'd2
  } state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  function automatic state_t sel_state(input logic ch);
    return (ch == CH1) ? SEL1 : SEL0;
  endfunction

endpackage

// File: rtl/mux2to1_bus.sv
// Combinational 2:1 mux for one beat (data + last flag).
//   seletor     in   select, CH0 picks d0/l0, CH1 picks d1/l1
//   d0, l0      in   channel 0 data and last flag
//   d1, l1      in   channel 1 data and last flag
//   data, last  out  selected beat
module mux2to1_bus
  import mux2to1_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              seletor,
  input  logic [DATA_W-1:0] d0,
  input  logic              l0,
  input  logic [DATA_W-1:0] d1,
  input  logic              l1,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  assign data = (seletor == CH1) ? d1 : d0;
  assign last = (seletor == CH1) ? l1 : l0;

endmodule

// File: rtl/mux2to1_arbiter.sv
// Round-robin packet arbiter sharing one 2:1 datapath mux between two
// streaming sources and one sink. One source is granted per packet; the
// selected beats are registered into a single-entry output stage.
//   clk, rst                      clock, async active-high reset
//   i0_valid/i0_data/i0_last      ch0 beat in;  i0_ready out
//   i1_valid/i1_data/i1_last      ch1 beat in;  i1_ready out
//   seletor                       registered mux select (0 = ch0, 1 = ch1)
//   out_valid/out_data/out_last   output beat; out_ready in from the sink
//   out_src                       channel the output beat came from
//   dbg_state                     current FSM state, for observation only
//
// Handshake: a beat moves on any interface in a cycle where valid && ready
// is seen at the rising edge. A source holds valid/data/last stable until
// accepted; ready may depend combinationally on out_ready.
module mux2to1_arbiter
  import mux2to1_arb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RR_INIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i0_valid,
  input  logic [DATA_W-1:0] i0_data,
  input  logic              i0_last,
  output logic              i0_ready,
  input  logic              i1_valid,
  input  logic [DATA_W-1:0] i1_data,
  input  logic              i1_last,
  output logic              i1_ready,
  output logic              seletor,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
  input  logic              out_ready,
  output logic [1:0]        dbg_state
);

  state_t            state, state_nxt;
  logic              prio;
  logic              stage_free;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;

  mux2to1_bus #(.DATA_W(DATA_W)) u_bus (
    .seletor (seletor),
    .d0      (i0_data),
    .l0      (i0_last),
    .d1      (i1_data),
    .l1      (i1_last),
    .data    (sel_data),
    .last    (sel_last)
  );

  // The output stage can take a beat when empty or draining this cycle.
  assign stage_free = !out_valid || out_ready;
  assign accept     = (i0_valid && i0_ready) || (i1_valid && i1_ready);
  assign dbg_state  = state;

  always_comb begin
    state_nxt = state;
    i0_ready  = 1'b0;
    i1_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (i0_valid && (!i1_valid || prio == CH0)) state_nxt = SEL0;
        else if (i1_valid)                          state_nxt = SEL1;
      end
      SEL0: begin
        i0_ready = stage_free;
        if (i0_valid && stage_free && sel_last) state_nxt = IDLE;
      end
      SEL1: begin
        i1_ready = stage_free;
        if (i1_valid && stage_free && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      prio    <= (RR_INIT != 0) ? CH1 : CH0;
      seletor <= CH0;
    end else begin
      state <= state_nxt;
      // Select is only retargeted when a new packet is granted, so it
      // keeps pointing at the previous owner while idle.
      if (state == IDLE && state_nxt != IDLE)
        seletor <= (state_nxt == sel_state(CH1)) ? CH1 : CH0;
      // Priority moves to the other channel once a packet completes.
      if (accept && sel_last)
        prio <= ~seletor;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= CH0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_src   <= seletor;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2to1_arbiter.sv
module tb_mux2to1_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       i0_valid, i0_last, i0_ready;
  logic [7:0] i0_data;
  logic       i1_valid, i1_last, i1_ready;
  logic [7:0] i1_data;
  logic       seletor;
  logic       out_valid, out_last, out_src, out_ready;
  logic [7:0] out_data;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int xfer_cnt = 0;
  int xfer_cyc[$];
  logic       abort;
  logic [9:0] exp_q[$];   // {src, last, data}

  mux2to1_arbiter #(.DATA_W(8), .RR_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .i0_valid(i0_valid), .i0_data(i0_data), .i0_last(i0_last), .i0_ready(i0_ready),
    .i1_valid(i1_valid), .i1_data(i1_data), .i1_last(i1_last), .i1_ready(i1_ready),
    .seletor(seletor),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // drivers
  task automatic drive(input logic ch, input logic v, input logic [7:0] d, input logic l);
    if (ch) begin i1_valid = v; i1_data = d; i1_last = l; end
    else    begin i0_valid = v; i0_data = d; i0_last = l; end
  endtask

  task automatic push_pkt(input logic ch, input int n, input logic [7:0] base, input logic [7:0] step);
    for (int k = 0; k < n; k++)
      exp_q.push_back({ch, (k == n - 1), 8'(base + step * k)});
  endtask

  task automatic send_pkt(input logic ch, input int n, input logic [7:0] base, input logic [7:0] step);
    int   guard;
    logic rdy;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (abort) break;
      drive(ch, 1'b1, 8'(base + step * k), (k == n - 1));
      guard = 0;
      forever begin
        #1;
        rdy = ch ? i1_ready : i0_ready;
        if (rdy || abort) break;
        guard++;
        if (guard > 200) begin
          check_val("drv_timeout", guard, 0);
          break;
        end
        @(negedge clk);
      end
      if (abort) break;
      @(posedge clk);
    end
    @(negedge clk);
    drive(ch, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_drain(input int max);
    int g = 0;
    while (exp_q.size() != 0 && g < max) begin
      @(negedge clk);
      g++;
    end
    check_val("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // scoreboard: a beat leaves the DUT when out_valid && out_ready at the edge
  always begin
    logic [9:0] exp;
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected", exp_q.size(), 1);
      end else begin
        exp = exp_q.pop_front();
        check_val("sb_beat", {out_src, out_last, out_data}, exp);
      end
      xfer_cyc.push_back(cyc);
      xfer_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, c0, g;
    rst = 1'b1; out_ready = 1'b1; abort = 1'b0;
    i0_valid = 0; i0_data = 0; i0_last = 0;
    i1_valid = 0; i1_data = 0; i1_last = 0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data",  out_data,  0);
    check_val("rst_out_last",  out_last,  0);
    check_val("rst_out_src",   out_src,   0);
    check_val("rst_seletor",   seletor,   0);
    check_val("rst_i0_ready",  i0_ready,  0);
    check_val("rst_i1_ready",  i1_ready,  0);
    check_val("rst_state",     dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // ch1-only traffic right after reset
    push_pkt(1'b1, 1, 8'h5A, 8'h00);
    send_pkt(1'b1, 1, 8'h5A, 8'h00);
    check_val("sel_hold_ch1", seletor, 1);
    wait_drain(50);

    // single source ch0: 11,22,33 back to back, 2-cycle latency
    push_pkt(1'b0, 3, 8'h11, 8'h11);
    idx = xfer_cnt;
    c0  = cyc + 1;
    send_pkt(1'b0, 3, 8'h11, 8'h11);
    wait_drain(50);
    check_val("lat_first", xfer_cyc[idx], c0 + 2);
    check_val("tput_b1",   xfer_cyc[idx+1] - xfer_cyc[idx], 1);
    check_val("tput_b2",   xfer_cyc[idx+2] - xfer_cyc[idx+1], 1);
    check_val("single_sel", seletor, 0);

    // contention after reset: ch0, bubble, ch1, bubble, ch0
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    push_pkt(1'b0, 2, 8'hA1, 8'h01);
    push_pkt(1'b1, 2, 8'hB1, 8'h01);
    push_pkt(1'b0, 2, 8'hC1, 8'h01);
    idx = xfer_cnt;
    fork
      begin
        send_pkt(1'b0, 2, 8'hA1, 8'h01);
        send_pkt(1'b0, 2, 8'hC1, 8'h01);
      end
      send_pkt(1'b1, 2, 8'hB1, 8'h01);
    join
    wait_drain(50);
    check_val("cont_gap0", xfer_cyc[idx+1] - xfer_cyc[idx],   1);
    check_val("cont_gap1", xfer_cyc[idx+2] - xfer_cyc[idx+1], 2);
    check_val("cont_gap2", xfer_cyc[idx+3] - xfer_cyc[idx+2], 1);
    check_val("cont_gap3", xfer_cyc[idx+4] - xfer_cyc[idx+3], 2);

    // backpressure: sink stalls 4 cycles with beat 0x60 in the output stage
    push_pkt(1'b1, 4, 8'h40, 8'h10);
    idx = xfer_cnt;
    fork
      send_pkt(1'b1, 4, 8'h40, 8'h10);
      begin
        g = 0;
        forever begin
          @(negedge clk); #3;
          if (xfer_cnt >= idx + 2 || g > 100) break;
          g++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
          #1;
          check_val("stall_i1_ready", i1_ready, 0);
          check_val("stall_valid",    out_valid, 1);
          check_val("stall_data",     out_data, 8'h60);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain(50);

    // ch1 shows up in the middle of a ch0 packet
    push_pkt(1'b0, 3, 8'h81, 8'h01);
    push_pkt(1'b1, 1, 8'h90, 8'h00);
    fork
      send_pkt(1'b0, 3, 8'h81, 8'h01);
      begin
        g = 0;
        forever begin
          @(negedge clk); #1;
          if (i0_ready || g > 100) break;
          g++;
        end
        fork
          send_pkt(1'b1, 1, 8'h90, 8'h00);
          begin
            @(negedge clk); #1;
            check_val("interloper_sel",   seletor, 0);
            check_val("interloper_state", dbg_state, 1);
          end
        join
      end
    join
    wait_drain(50);
    check_val("sel_after_interloper", seletor, 1);

    // one-beat ch0 packet moves priority to ch1
    push_pkt(1'b0, 1, 8'hEE, 8'h00);
    send_pkt(1'b0, 1, 8'hEE, 8'h00);
    wait_drain(50);

    // reset in the middle of a 4-beat packet
    push_pkt(1'b0, 4, 8'hD0, 8'h01);
    idx = xfer_cnt;
    fork
      send_pkt(1'b0, 4, 8'hD0, 8'h01);
      begin
        g = 0;
        forever begin
          @(negedge clk); #3;
          if (xfer_cnt >= idx + 2 || g > 100) break;
          g++;
        end
        @(posedge clk); #2;
        check_val("pre_rst_valid", out_valid, 1);
        rst = 1'b1; abort = 1'b1;
        #1;
        check_val("mid_rst_valid",   out_valid, 0);
        check_val("mid_rst_data",    out_data,  0);
        check_val("mid_rst_last",    out_last,  0);
        check_val("mid_rst_seletor", seletor,   0);
        check_val("mid_rst_i0_rdy",  i0_ready,  0);
        check_val("mid_rst_state",   dbg_state, 0);
        exp_q.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
      end
    join
    abort = 1'b0;

    // priority restarts at ch0 after reset
    push_pkt(1'b0, 1, 8'hA5, 8'h00);
    push_pkt(1'b1, 1, 8'hB5, 8'h00);
    fork
      send_pkt(1'b0, 1, 8'hA5, 8'h00);
      send_pkt(1'b1, 1, 8'hB5, 8'h00);
    join
    wait_drain(50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
